mw_pipe_stage: RTL and testbench

- Parametrised successor to the fixed MEM/WB pipeline register.
- Carries a packed WIDTH-bit payload (IR, WriteReg, ReadData, ALUOut, PC, PC8 by default) from MEM to WB.
- Uses a valid/ready handshake with a 2-entry skid buffer, so WB back-pressure (multi-cycle writeback, regfile port conflict) never drops an instruction.
- Supports synchronous flush for exceptions/branch squash and zero-payload bubble output.

---
 rtl/mw_pkg.sv | 66 ++++++
 rtl/mw_pipe_stage.sv | 110 +++++++++++
 tb/tb_mw_pipe_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mw_pkg.sv
// Shared MEM/WB payload definitions: pipeline state encoding, field layout
// of the packed payload, and pack/unpack helpers for the MEM and WB stages.
package mw_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } mw_state_e;

  localparam int MW_WIDTH   = 165;
  localparam int IR_W       = 32;
  localparam int WREG_W     = 5;
  localparam int RDATA_W    = 32;
  localparam int ALUOUT_W   = 32;
  localparam int PC_W       = 32;
  localparam int PC8_W      = 32;

  // PC8 occupies the low bits; IR sits at the top of the word.
  localparam int PC8_LSB    = 0;
  localparam int PC_LSB     = PC8_LSB + PC8_W;
  localparam int ALUOUT_LSB = PC_LSB + PC_W;
  localparam int RDATA_LSB  = ALUOUT_LSB + ALUOUT_W;
  localparam int WREG_LSB   = RDATA_LSB + RDATA_W;
  localparam int IR_LSB     = WREG_LSB + WREG_W;

  typedef struct packed {
    logic [IR_W-1:0]     ir;
    logic [WREG_W-1:0]   wreg;
    logic [RDATA_W-1:0]  rdata;
    logic [ALUOUT_W-1:0] aluout;
    logic [PC_W-1:0]     pc;
    logic [PC8_W-1:0]    pc8;
  } mw_fields_t;

  function automatic logic [MW_WIDTH-1:0] mw_pack(
    input logic [IR_W-1:0]     ir,
    input logic [WREG_W-1:0]   wreg,
    input logic [RDATA_W-1:0]  rdata,
    input logic [ALUOUT_W-1:0] aluout,
    input logic [PC_W-1:0]     pc,
    input logic [PC8_W-1:0]    pc8
  );
    logic [MW_WIDTH-1:0] word;
    word = {MW_WIDTH{1'b0}};
    word[IR_LSB     +: IR_W]     = ir;
    word[WREG_LSB   +: WREG_W]   = wreg;
    word[RDATA_LSB  +: RDATA_W]  = rdata;
    word[ALUOUT_LSB +: ALUOUT_W] = aluout;
    word[PC_LSB     +: PC_W]     = pc;
    word[PC8_LSB    +: PC8_W]    = pc8;
    return word;
  endfunction

  function automatic mw_fields_t mw_unpack(input logic [MW_WIDTH-1:0] word);
    mw_fields_t f;
    f.ir     = word[IR_LSB     +: IR_W];
    f.wreg   = word[WREG_LSB   +: WREG_W];
    f.rdata  = word[RDATA_LSB  +: RDATA_W];
    f.aluout = word[ALUOUT_LSB +: ALUOUT_W];
    f.pc     = word[PC_LSB     +: PC_W];
    f.pc8    = word[PC8_LSB    +: PC8_W];
    return f;
  endfunction

endpackage

// File: rtl/mw_pipe_stage.sv
// MEM/WB pipeline register with valid/ready handshake and 2-entry skid buffer.
// Optional stall counter enabled by defining STALL_CNT_EN.
module mw_pipe_stage
  import mw_pkg::*;
#(
  parameter int               WIDTH      = MW_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  mw_state_e        state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             consume_s;

  // Handshake flags depend only on registered state, never on out_ready.
  assign in_ready_s  = (state_r != SKID);
  assign out_valid_s = (state_r != EMPTY);
  assign accept_s    = in_valid && in_ready_s;
  assign consume_s   = out_valid_s && out_ready;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = out_valid_s ? main_r : BUBBLE_VAL;

  // Entry count from state.
  always_comb begin
    occupancy = 2'd0;
    case (state_r)
      EMPTY:   occupancy = 2'd0;
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State and storage update: reset, then flush, then handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= EMPTY;
      main_r  <= BUBBLE_VAL;
      skid_r  <= BUBBLE_VAL;
    end else if (FLUSH) begin
      state_r <= EMPTY;
      main_r  <= BUBBLE_VAL;
      skid_r  <= BUBBLE_VAL;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_r  <= in_data;
            state_r <= FULL;
          end
        end
        FULL: begin
          if (accept_s && consume_s) begin
            main_r <= in_data;
          end else if (consume_s) begin
            state_r <= EMPTY;
          end else if (accept_s) begin
            skid_r  <= in_data;
            state_r <= SKID;
          end
        end
        SKID: begin
          if (consume_s) begin
            main_r  <= skid_r;
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles MEM was held off; FLUSH does not clear it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_r <= 32'd0;
    end else if (in_valid && !in_ready_s && !FLUSH && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mw_pipe_stage.sv
// Self-checking bench for mw_pipe_stage: directed vector table, stall-counter
// sequence (STALL_CNT_EN builds) and randomized run against a queue model.
module tb_mw_pipe_stage;
  import mw_pkg::*;

  localparam int W = MW_WIDTH;

  logic         CLK;
  logic         RESET;
  logic         FLUSH;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of held payloads, capacity 2.
  logic [W-1:0] mq[$];
  int unsigned  m_stall = 0;

  mw_pipe_stage #(.WIDTH(W), .BUBBLE_VAL({W{1'b0}})) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare DUT outputs with what the model's current contents imply.
  task automatic check_model(input string tag);
    logic [W-1:0] exp_d;
    exp_d = (mq.size() > 0) ? mq[0] : {W{1'b0}};
    chk({tag, ".out_valid"}, W'(out_valid), W'(mq.size() != 0));
    chk({tag, ".out_data"},  out_data, exp_d);
    chk({tag, ".in_ready"},  W'(in_ready), W'(mq.size() < 2));
    chk({tag, ".occupancy"}, W'(occupancy), W'(mq.size()));
`ifdef STALL_CNT_EN
    chk({tag, ".stall_cycles"}, W'(stall_cycles), W'(m_stall));
`endif
  endtask

  task automatic model_update(input logic v, input logic [W-1:0] d, input logic r,
                              input logic f, input logic rs);
    int sz;
    sz = mq.size();
    if (rs) begin
      mq.delete();
      m_stall = 0;
    end else if (f) begin
      mq.delete();
    end else begin
      if (v && sz == 2 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (r && sz > 0) void'(mq.pop_front());
      if (v && sz < 2) mq.push_back(d);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs, clock, update model.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic r, input logic f, input logic rs);
    in_valid = v; in_data = d; out_ready = r; FLUSH = f; RESET = rs;
    #2;
    check_model(tag);
    @(posedge CLK);
    model_update(v, d, r, f, rs);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    logic         rs;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_ready;
    logic [1:0]   e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input int d, input logic r, input logic f,
                              input logic rs, input logic ev, input int ed,
                              input logic er, input logic [1:0] eo);
    vec_t t;
    t.v = v; t.d = W'(d); t.r = r; t.f = f; t.rs = rs;
    t.e_valid = ev; t.e_data = W'(ed); t.e_ready = er; t.e_occ = eo;
    return t;
  endfunction

  function automatic logic [W-1:0] rand_payload();
    return mw_pack($urandom, 5'($urandom), $urandom, $urandom, $urandom, $urandom);
  endfunction

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; in_data = {W{1'b0}}; out_ready = 1'b0;
    @(posedge CLK); #1;
    mq.delete(); m_stall = 0;

    // Expected outputs are the values after the clock edge of each vector.
    //               v  data r  f  rs   ev  edata er occ
    vecs.push_back(mk(1'b0, 0,    1'b0, 1'b0, 1'b1, 1'b0, 0,    1'b1, 2'd0)); // reset
    vecs.push_back(mk(1'b1, 'h1,  1'b1, 1'b0, 1'b0, 1'b1, 'h1,  1'b1, 2'd1)); // stream
    vecs.push_back(mk(1'b1, 'h2,  1'b1, 1'b0, 1'b0, 1'b1, 'h2,  1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 'h3,  1'b1, 1'b0, 1'b0, 1'b1, 'h3,  1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 'h4,  1'b1, 1'b0, 1'b0, 1'b1, 'h4,  1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 0,    1'b1, 1'b0, 1'b0, 1'b0, 0,    1'b1, 2'd0));
    vecs.push_back(mk(1'b1, 'hA,  1'b0, 1'b0, 1'b0, 1'b1, 'hA,  1'b1, 2'd1)); // back-pressure
    vecs.push_back(mk(1'b1, 'hB,  1'b0, 1'b0, 1'b0, 1'b1, 'hA,  1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 'hC,  1'b0, 1'b0, 1'b0, 1'b1, 'hA,  1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 'hC,  1'b1, 1'b0, 1'b0, 1'b1, 'hB,  1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 'hC,  1'b1, 1'b0, 1'b0, 1'b1, 'hC,  1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 0,    1'b1, 1'b0, 1'b0, 1'b0, 0,    1'b1, 2'd0));
    vecs.push_back(mk(1'b1, 'h5,  1'b0, 1'b0, 1'b0, 1'b1, 'h5,  1'b1, 2'd1)); // flush in SKID
    vecs.push_back(mk(1'b1, 'h6,  1'b0, 1'b0, 1'b0, 1'b1, 'h5,  1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 'h7,  1'b1, 1'b1, 1'b0, 1'b0, 0,    1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 0,    1'b1, 1'b0, 1'b0, 1'b0, 0,    1'b1, 2'd0));
    vecs.push_back(mk(1'b1, 'h8,  1'b0, 1'b0, 1'b0, 1'b1, 'h8,  1'b1, 2'd1)); // reset in FULL
    vecs.push_back(mk(1'b1, 'h9,  1'b0, 1'b0, 1'b1, 1'b0, 0,    1'b1, 2'd0));
    vecs.push_back(mk(1'b1, 'hE,  1'b1, 1'b0, 1'b0, 1'b1, 'hE,  1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 0,    1'b1, 1'b0, 1'b0, 1'b0, 0,    1'b1, 2'd0));
    // Flush while empty with an offer: the offer is discarded.
    vecs.push_back(mk(1'b1, 'hF,  1'b0, 1'b1, 1'b0, 1'b0, 0,    1'b1, 2'd0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tag, vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].rs);
      chk({tag, ".post_valid"}, W'(out_valid), W'(vecs[i].e_valid));
      chk({tag, ".post_data"},  out_data, vecs[i].e_data);
      chk({tag, ".post_ready"}, W'(in_ready), W'(vecs[i].e_ready));
      chk({tag, ".post_occ"},   W'(occupancy), W'(vecs[i].e_occ));
    end

`ifdef STALL_CNT_EN
    // Fill to SKID, hold off MEM for 3 cycles, then flush with an offer.
    cycle("st_rst", 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1);
    cycle("st_f1", 1'b1, W'(32'h11), 1'b0, 1'b0, 1'b0);
    cycle("st_f2", 1'b1, W'(32'h12), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle("st_hold", 1'b1, W'(32'h13), 1'b0, 1'b0, 1'b0);
    cycle("st_flush", 1'b1, W'(32'h13), 1'b0, 1'b1, 1'b0);
    chk("stall_after_flush", W'(stall_cycles), W'(32'd3));
    cycle("st_reset", 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1);
    chk("stall_after_reset", W'(stall_cycles), W'(32'd0));
`endif

    // Sustained accept+consume run, then random traffic with rare flush/reset.
    for (int k = 0; k < 10; k++)
      cycle("thru", 1'b1, rand_payload(), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 400; k++) begin
      logic v, r, f, rs;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      f  = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 59) == 0);
      cycle("rand", v, rand_payload(), r, f, rs);
    end
    cycle("final", 1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0);
    check_model("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
